// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life generation sequencer:
// grid defaults, coordinate widths, FSM state encoding and a speed helper.
package gol_pkg;

    localparam int GRID_W_DEF = 80;
    localparam int GRID_H_DEF = 60;
    localparam int X_W        = 7;
    localparam int Y_W        = 6;
    localparam int SPEED_W    = 4;
    localparam int GEN_W      = 16;

    // Sequencer state encoding, kept as plain constants so older tools
    // and hand-written netlist probes can match on the raw codes.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_ENGINE = 3'd2;
    localparam state_t ST_SWAP   = 3'd3;
    localparam state_t ST_CLEAR  = 3'd4;

    // A speed setting of zero behaves like one frame per generation.
    function automatic logic [SPEED_W-1:0] eff_speed(input logic [SPEED_W-1:0] s);
        return (s == '0) ? SPEED_W'(1) : s;
    endfunction

endpackage

// File: rtl/gol_gen_sequencer_if.sv
// Engine handshake and clear write port between the sequencer and the
// Game of Life engine / cell buffers.
interface gol_gen_sequencer_if;

    logic                    start_update;
    logic                    simulating;
    logic                    engine_busy;
    logic                    buf_sel;
    logic                    clr_we;
    logic [gol_pkg::X_W-1:0] clr_x;
    logic [gol_pkg::Y_W-1:0] clr_y;

    modport master (
        output start_update,
        output simulating,
        output buf_sel,
        output clr_we,
        output clr_x,
        output clr_y,
        input  engine_busy
    );

    modport slave (
        input  start_update,
        input  simulating,
        input  buf_sel,
        input  clr_we,
        input  clr_x,
        input  clr_y,
        output engine_busy
    );

endinterface

// File: rtl/gol_raster_counter.sv
// Raster address generator for the clear sweep: x runs fastest, y steps
// when x wraps. wrap flags the last cell so the caller can finish the sweep
// on the same edge the counter returns to (0,0).
module gol_raster_counter
    import gol_pkg::*;
#(
    parameter int W = GRID_W_DEF,
    parameter int H = GRID_H_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           wrap
);

    logic x_last;
    logic y_last;

    assign x_last = (x == X_W'(W - 1));
    assign y_last = (y == Y_W'(H - 1));
    assign wrap   = x_last && y_last;

    // Advance one cell per enabled cycle, wrapping back to the origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/gol_gen_sequencer.sv
// Generation sequencer: paces Game of Life generations against VGA frames,
// hands each generation to the engine, swaps display buffers and runs the
// whole-grid clear sweep.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for a due frame (run), a step, or a clear
//   START  | start_update raised until the engine reports busy
//   ENGINE | engine computing; wait for busy to drop
//   SWAP   | one cycle: flip buffers, count generation, pulse gen_done
//   CLEAR  | one cell per cycle written with 0 across the grid
module gol_gen_sequencer
    import gol_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               step,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed,
    input  logic               frame_tick,
    gol_gen_sequencer_if.master bus,
    output logic [GEN_W-1:0]   gen_count,
    output logic               gen_done,
    output logic               seq_busy
);

    state_t             state;
    state_t             state_nx;
    logic [SPEED_W-1:0] frame_cnt;
    logic [SPEED_W:0]   frame_inc;
    logic               due;
    logic               clr_pend;
    logic               tick_hit;
    logic               tick_due;
    logic               go_start;
    logic               swap_enter;
    logic               sweep_wrap;
    logic               sweep_done;
    logic               start_update_r;
    logic               simulating_r;
    logic               buf_sel_r;
    logic               clr_we_r;

    gol_raster_counter #(
        .W (GRID_W),
        .H (GRID_H)
    ) u_raster (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_CLEAR),
        .x     (bus.clr_x),
        .y     (bus.clr_y),
        .wrap  (sweep_wrap)
    );

    assign tick_hit   = (state == ST_IDLE) && frame_tick;
    assign frame_inc  = {1'b0, frame_cnt} + (SPEED_W + 1)'(1);
    assign tick_due   = tick_hit && (frame_inc >= {1'b0, eff_speed(speed)});
    assign go_start   = (state == ST_IDLE) && (state_nx == ST_START);
    assign swap_enter = (state == ST_ENGINE) && (state_nx == ST_SWAP);
    assign sweep_done = (state == ST_CLEAR) && sweep_wrap;

    // Next-state decode; clear wins over step, and step only counts when not running.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (clear)
                    state_nx = ST_CLEAR;
                else if ((run && due) || (step && !run))
                    state_nx = ST_START;
            end
            ST_START: begin
                if (bus.engine_busy)
                    state_nx = ST_ENGINE;
            end
            ST_ENGINE: begin
                if (!bus.engine_busy)
                    state_nx = ST_SWAP;
            end
            ST_SWAP: begin
                state_nx = (clr_pend || clear) ? ST_CLEAR : ST_IDLE;
            end
            ST_CLEAR: begin
                if (sweep_wrap)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register and outputs registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            start_update_r <= 1'b0;
            simulating_r   <= 1'b0;
            clr_we_r       <= 1'b0;
            seq_busy       <= 1'b0;
            gen_done       <= 1'b0;
        end else begin
            state          <= state_nx;
            start_update_r <= (state_nx == ST_START);
            simulating_r   <= (state_nx == ST_START) || (state_nx == ST_ENGINE);
            clr_we_r       <= (state_nx == ST_CLEAR);
            seq_busy       <= (state_nx != ST_IDLE);
            gen_done       <= swap_enter;
        end
    end

    // Frame pacing, due flag and deferred clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            due       <= 1'b0;
            clr_pend  <= 1'b0;
        end else if (sweep_done) begin
            frame_cnt <= '0;
            due       <= 1'b0;
            clr_pend  <= 1'b0;
        end else begin
            if (tick_hit)
                frame_cnt <= tick_due ? '0 : frame_inc[SPEED_W-1:0];
            if (tick_due)
                due <= 1'b1;
            else if (go_start)
                due <= 1'b0;
            if (state == ST_SWAP)
                clr_pend <= 1'b0;
            else if (clear && ((state == ST_START) || (state == ST_ENGINE)))
                clr_pend <= 1'b1;
        end
    end

    // Buffer select and generation count: advance on SWAP, zero after a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_sel_r <= 1'b0;
            gen_count <= '0;
        end else if (sweep_done) begin
            buf_sel_r <= 1'b0;
            gen_count <= '0;
        end else if (swap_enter) begin
            buf_sel_r <= ~buf_sel_r;
            gen_count <= gen_count + GEN_W'(1);
        end
    end

    assign bus.start_update = start_update_r;
    assign bus.simulating   = simulating_r;
    assign bus.buf_sel      = buf_sel_r;
    assign bus.clr_we       = clr_we_r;

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// Bench for gol_gen_sequencer: a small engine model, negedge monitors,
// a frame-pacing vector table and directed multi-cycle sequences.
module tb_gol_gen_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       step;
    logic       clear;
    logic [3:0] speed;
    logic       frame_tick;
    logic [15:0] gen_count;
    logic       gen_done;
    logic       seq_busy;

    gol_gen_sequencer_if bus();

    gol_gen_sequencer #(
        .GRID_W (80),
        .GRID_H (60)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .clear      (clear),
        .speed      (speed),
        .frame_tick (frame_tick),
        .bus        (bus),
        .gen_count  (gen_count),
        .gen_done   (gen_done),
        .seq_busy   (seq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // engine model: answers start_update with busy held for eng_len cycles
    int eng_len = 10;
    int eng_cnt = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.engine_busy <= 1'b0;
            eng_cnt         <= 0;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1)
                bus.engine_busy <= 1'b0;
        end else if (bus.start_update && !bus.engine_busy) begin
            bus.engine_busy <= 1'b1;
            eng_cnt         <= eng_len;
        end
    end

    // monitors
    int   su_eps  = 0;
    int   gd_cnt  = 0;
    int   clr_cnt = 0;
    logic su_prev = 1'b0;
    logic we_prev = 1'b0;
    int   last_x = 0, last_y = 0, first_x = -1, first_y = -1;
    always @(negedge clk) begin
        if (bus.start_update && !su_prev) su_eps++;
        su_prev = bus.start_update;
        if (gen_done) gd_cnt++;
        if (bus.clr_we) begin
            clr_cnt++;
            last_x = int'(bus.clr_x);
            last_y = int'(bus.clr_y);
            if (!we_prev) begin
                first_x = int'(bus.clr_x);
                first_y = int'(bus.clr_y);
            end
        end
        we_prev = bus.clr_we;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (seq_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (seq_busy) begin
            n_fail++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
        end
    endtask

    task automatic pulse_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic clear_and_wait(input string name);
        pulse_clear();
        wait_idle(6000, name);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] speed;
        int         ticks;
        int         exp_gens;
    } pace_vec_t;

    pace_vec_t vecs[6];

    int su0, gd0, cnt0, n;
    logic [18:0] rest;

    initial begin
        vecs[0] = '{speed: 4'd3,  ticks: 12, exp_gens: 4};
        vecs[1] = '{speed: 4'd0,  ticks: 5,  exp_gens: 5};
        vecs[2] = '{speed: 4'd1,  ticks: 4,  exp_gens: 4};
        vecs[3] = '{speed: 4'd2,  ticks: 5,  exp_gens: 2};
        vecs[4] = '{speed: 4'd15, ticks: 15, exp_gens: 1};
        vecs[5] = '{speed: 4'd4,  ticks: 3,  exp_gens: 0};

        rst_n = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0;
        speed = 4'd0; frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gen_count", 32'(gen_count), 0);
        chk("rst_outputs", 32'({bus.start_update, bus.simulating, bus.buf_sel, gen_done,
                                bus.clr_we, bus.clr_x, bus.clr_y, seq_busy}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_release_busy", 32'(seq_busy), 0);

        // single steps with differing engine latencies
        eng_len = 3;
        su0 = su_eps; gd0 = gd_cnt;
        pulse_step();
        chk("step_latency_start_update", 32'(bus.start_update), 1);
        chk("step_latency_simulating", 32'(bus.simulating), 1);
        wait_idle(100, "step1_idle");
        repeat (2) @(negedge clk);
        chk("step1_su_episodes", 32'(su_eps - su0), 1);
        chk("step1_gen_done", 32'(gd_cnt - gd0), 1);
        chk("step1_buf_sel", 32'(bus.buf_sel), 1);
        chk("step1_gen_count", 32'(gen_count), 1);

        eng_len = 50;
        su0 = su_eps; gd0 = gd_cnt;
        pulse_step();
        wait_idle(200, "step2_idle");
        repeat (2) @(negedge clk);
        chk("step2_su_episodes", 32'(su_eps - su0), 1);
        chk("step2_gen_done", 32'(gd_cnt - gd0), 1);
        chk("step2_buf_sel", 32'(bus.buf_sel), 0);
        chk("step2_gen_count", 32'(gen_count), 2);

        eng_len = 7;
        pulse_step();
        wait_idle(100, "step3_idle");
        repeat (2) @(negedge clk);
        chk("step3_gen_count", 32'(gen_count), 3);

        // step ignored while running
        run = 1'b1; speed = 4'd15;
        su0 = su_eps;
        pulse_step();
        repeat (20) @(negedge clk);
        chk("step_run_ignored", 32'(su_eps - su0), 0);
        chk("step_run_gen_count", 32'(gen_count), 3);
        run = 1'b0;
        repeat (2) @(negedge clk);

        // clear and step together: clear wins; step/tick ignored mid-sweep
        su0 = su_eps; cnt0 = clr_cnt;
        @(negedge clk) begin clear = 1'b1; step = 1'b1; end
        @(negedge clk) begin clear = 1'b0; step = 1'b0; end
        chk("clrstep_clr_we", 32'(bus.clr_we), 1);
        chk("clrstep_start_update", 32'(bus.start_update), 0);
        repeat (100) @(negedge clk);
        pulse_step();
        pulse_tick();
        wait_idle(6000, "clrstep_idle");
        repeat (3) @(negedge clk);
        chk("clrstep_we_cycles", 32'(clr_cnt - cnt0), 4800);
        chk("clrstep_first_xy", 32'({first_y[15:0], first_x[15:0]}), 0);
        chk("clrstep_last_xy", 32'({last_y[15:0], last_x[15:0]}), {16'd59, 16'd79});
        chk("clrstep_no_start", 32'(su_eps - su0), 0);
        chk("clrstep_gen_count", 32'(gen_count), 0);
        chk("clrstep_buf_sel", 32'(bus.buf_sel), 0);

        // clear arriving during ENGINE is held until after SWAP
        eng_len = 20;
        gd0 = gd_cnt; cnt0 = clr_cnt;
        pulse_step();
        n = 0;
        while (!(bus.simulating && !bus.start_update) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pend_reached_engine", 32'(bus.simulating && !bus.start_update), 1);
        pulse_clear();
        chk("pend_no_early_clear", 32'(bus.clr_we), 0);
        wait_idle(6000, "pend_idle");
        repeat (3) @(negedge clk);
        chk("pend_gen_done", 32'(gd_cnt - gd0), 1);
        chk("pend_we_cycles", 32'(clr_cnt - cnt0), 4800);
        chk("pend_last_xy", 32'({last_y[15:0], last_x[15:0]}), {16'd59, 16'd79});
        chk("pend_gen_count", 32'(gen_count), 0);
        chk("pend_buf_sel", 32'(bus.buf_sel), 0);
        chk("pend_clr_xy_home", 32'({bus.clr_we, bus.clr_x, bus.clr_y}), 0);

        // frame pacing table
        eng_len = 10;
        for (int i = 0; i < 6; i++) begin
            clear_and_wait($sformatf("pace%0d_clear", i));
            speed = vecs[i].speed;
            run   = 1'b1;
            gd0   = gd_cnt;
            for (int t = 0; t < vecs[i].ticks; t++) begin
                pulse_tick();
                repeat (40) @(negedge clk);
            end
            run = 1'b0;
            wait_idle(100, $sformatf("pace%0d_idle", i));
            repeat (2) @(negedge clk);
            chk($sformatf("pace%0d_gen_count", i), 32'(gen_count), 32'(vecs[i].exp_gens));
            chk($sformatf("pace%0d_gen_done", i), 32'(gd_cnt - gd0), 32'(vecs[i].exp_gens));
            chk($sformatf("pace%0d_buf_sel", i), 32'(bus.buf_sel), 32'(vecs[i].exp_gens % 2));
        end

        // run dropped in START: generation completes, nothing further starts
        clear_and_wait("drop_clear");
        speed = 4'd1; run = 1'b1;
        su0 = su_eps; gd0 = gd_cnt;
        pulse_tick();
        n = 0;
        while (!bus.start_update && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("drop_in_start", 32'(bus.start_update), 1);
        run = 1'b0;
        wait_idle(100, "drop_idle");
        for (int t = 0; t < 3; t++) begin
            pulse_tick();
            repeat (20) @(negedge clk);
        end
        chk("drop_su_episodes", 32'(su_eps - su0), 1);
        chk("drop_gen_done", 32'(gd_cnt - gd0), 1);
        chk("drop_gen_count", 32'(gen_count), 1);

        // reset in the middle of a clear sweep, at cell index 1000 = (40,12)
        pulse_clear();
        n = 0;
        while (!(bus.clr_we && bus.clr_x == 7'd40 && bus.clr_y == 6'd12) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("midclr_reached_1000", 32'({bus.clr_we, bus.clr_x, bus.clr_y}), {1'b1, 7'd40, 6'd12});
        rst_n = 1'b0;
        #1;
        rest = {bus.start_update, bus.simulating, bus.buf_sel, gen_done,
                bus.clr_we, bus.clr_x, bus.clr_y, seq_busy};
        chk("midclr_rst_gen_count", 32'(gen_count), 0);
        chk("midclr_rst_outputs", 32'(rest), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt0 = clr_cnt;
        repeat (30) @(negedge clk);
        chk("midclr_no_more_we", 32'(clr_cnt - cnt0), 0);
        chk("midclr_idle", 32'({seq_busy, gen_count}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
